// File: rtl/frame_key_latch.sv
// Debounces one player's keycode, decodes it against eight control keycodes and
// latches held levels and accumulated press events once per video frame.
module frame_key_latch #(
    parameter logic [15:0] DEBOUNCE = 16'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  keycode,
    input  logic [63:0] controls,
    input  logic        frame_clk,
    output logic [7:0]  held,
    output logic [7:0]  pressed,
    output logic        frame_tick
);

    logic        sync1;
    logic        sync2;
    logic        sync3;
    logic        tick;
    logic [7:0]  last_code;
    logic [7:0]  stable_code;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [7:0]  level;
    logic [7:0]  level_prev;
    logic [7:0]  key_edge;
    logic [7:0]  acc;

    assign tick     = sync2 & ~sync3;
    assign cnt_next = cnt + 16'd1;
    assign key_edge = level & ~level_prev;

    // Output bit j follows the packing of controls: bit 7 is index 0 ([63:56]).
    always_comb begin
        level = 8'h00;
        for (int j = 0; j < 8; j++) begin
            level[j] = (stable_code != 8'h00) && (stable_code == controls[8*j +: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            sync1      <= frame_clk;
            sync2      <= sync1;
            sync3      <= sync2;
            frame_tick <= tick;
        end
    end

    // Any change of keycode restarts the count; the count saturates at DEBOUNCE.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_code   <= 8'h00;
            cnt         <= 16'd0;
            stable_code <= 8'h00;
        end else if (keycode != last_code) begin
            last_code <= keycode;
            cnt       <= 16'd0;
        end else if (cnt < DEBOUNCE) begin
            cnt <= cnt_next;
            if (cnt_next == DEBOUNCE) begin
                stable_code <= last_code;
            end
        end
    end

    // An edge coinciding with the tick goes straight into that frame's report.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_prev <= 8'h00;
            acc        <= 8'h00;
            held       <= 8'h00;
            pressed    <= 8'h00;
        end else begin
            level_prev <= level;
            if (tick) begin
                pressed <= acc | key_edge;
                held    <= level;
                acc     <= 8'h00;
            end else begin
                acc <= acc | key_edge;
            end
        end
    end

endmodule

// File: tb/tb_frame_key_latch.sv
// Randomized scoreboard bench for frame_key_latch: a frame-level reference model
// predicts each tick's held/pressed report; a monitor checks the DUT every cycle.
module tb_frame_key_latch;

    localparam logic [15:0] DEB  = 16'd4;
    localparam logic [63:0] CTRL = {8'd26, 8'd22, 8'd04, 8'd07, 8'd20, 8'd08, 8'd30, 8'd32};

    typedef struct packed {
        logic [7:0] held;
        logic [7:0] pressed;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  keycode;
    logic [63:0] controls;
    logic        frame_clk;
    logic [7:0]  held;
    logic [7:0]  pressed;
    logic        frame_tick;

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    logic [7:0] exp_held = 8'h00;
    logic [7:0] exp_pressed = 8'h00;

    frame_key_latch #(.DEBOUNCE(DEB)) dut (
        .clk(clk),
        .reset(reset),
        .keycode(keycode),
        .controls(controls),
        .frame_clk(frame_clk),
        .held(held),
        .pressed(pressed),
        .frame_tick(frame_tick)
    );

    always #10 clk = ~clk;

    // Which control slots name this code; slot i (i=0 is the top byte) reports on bit 7-i.
    function automatic logic [7:0] keysDown(input logic [7:0] code, input logic [63:0] c);
        logic [7:0] r;
        r = 8'h00;
        if (code != 8'h00) begin
            for (int i = 0; i < 8; i++) begin
                if (c[63-8*i -: 8] == code) r[7-i] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] code, input logic fc, input int cycles);
        keycode   = code;
        frame_clk = fc;
        repeat (cycles) @(negedge clk);
    endtask

    // Reference model: a key is accepted once it has been sampled DEB+1 times in a row;
    // a frame report is due two samples after frame_clk is first seen high.
    initial begin
        logic [7:0] run_val;
        logic [7:0] accepted;
        logic [7:0] prev_down;
        logic [7:0] pending;
        logic [7:0] down;
        logic [7:0] rises;
        int         run_len;
        bit         fc_hist[$];
        run_val   = 8'h00;
        accepted  = 8'h00;
        prev_down = 8'h00;
        pending   = 8'h00;
        run_len   = 1;
        fc_hist   = '{0, 0, 0};
        forever begin
            @(posedge clk);
            if (reset) begin
                run_val     = 8'h00;
                accepted    = 8'h00;
                prev_down   = 8'h00;
                pending     = 8'h00;
                run_len     = 1;
                fc_hist     = '{0, 0, 0};
                expq.delete();
                exp_held    = 8'h00;
                exp_pressed = 8'h00;
            end else begin
                down  = keysDown(accepted, controls);
                rises = down & ~prev_down;
                if (fc_hist[1] && !fc_hist[0]) begin
                    expq.push_back('{held: down, pressed: pending | rises});
                    pending = 8'h00;
                end else begin
                    pending = pending | rises;
                end
                prev_down = down;
                if (keycode == run_val) begin
                    if (run_len <= int'(DEB)) run_len++;
                end else begin
                    run_val = keycode;
                    run_len = 1;
                end
                if (run_len == int'(DEB) + 1) accepted = run_val;
                void'(fc_hist.pop_front());
                fc_hist.push_back(frame_clk);
            end
        end
    end

    // Monitor: a tick must appear exactly when a report is queued; outputs hold otherwise.
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            checkOutput("frame_tick", {7'd0, frame_tick}, {7'd0, expq.size() > 0});
            if (expq.size() > 0) begin
                e           = expq.pop_front();
                exp_held    = e.held;
                exp_pressed = e.pressed;
            end
            checkOutput("held", held, exp_held);
            checkOutput("pressed", pressed, exp_pressed);
        end
    end

    initial begin
        int a;
        int b;
        int pick;
        logic [7:0] code;
        reset     = 1'b1;
        keycode   = 8'h00;
        frame_clk = 1'b0;
        controls  = CTRL;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        applyStimulus(8'd0, 1'b1, 4);
        applyStimulus(8'd0, 1'b0, 4);

        $display("[TB] debounce latency with key 26");
        applyStimulus(8'd26, 1'b0, 8);
        applyStimulus(8'd26, 1'b1, 4);
        applyStimulus(8'd26, 1'b0, 6);
        applyStimulus(8'd26, 1'b1, 4);
        applyStimulus(8'd26, 1'b0, 4);
        applyStimulus(8'd0, 1'b0, 8);

        $display("[TB] glitch rejection with key 30");
        applyStimulus(8'd30, 1'b0, 3);
        applyStimulus(8'd0, 1'b0, 8);
        applyStimulus(8'd0, 1'b1, 4);
        applyStimulus(8'd0, 1'b0, 4);

        $display("[TB] accumulation of 04 then 32");
        applyStimulus(8'd4, 1'b0, 7);
        applyStimulus(8'd0, 1'b0, 7);
        applyStimulus(8'd32, 1'b0, 7);
        applyStimulus(8'd32, 1'b1, 4);
        applyStimulus(8'd32, 1'b0, 4);

        $display("[TB] tick-aligned press of 20");
        applyStimulus(8'd20, 1'b0, 1);
        applyStimulus(8'd20, 1'b0, 1);
        applyStimulus(8'd20, 1'b1, 6);
        applyStimulus(8'd20, 1'b0, 6);

        $display("[TB] reset while key 22 is down");
        applyStimulus(8'd22, 1'b0, 8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(8'd22, 1'b0, 7);
        applyStimulus(8'd22, 1'b1, 4);
        applyStimulus(8'd22, 1'b0, 4);

        $display("[TB] null key in controls");
        controls[39:32] = 8'h00;
        applyStimulus(8'd0, 1'b0, 10);
        applyStimulus(8'd0, 1'b1, 4);
        applyStimulus(8'd0, 1'b0, 4);
        controls = CTRL;

        $display("[TB] fast frame_clk toggling");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'd8, 1'b1, 1);
            applyStimulus(8'd8, 1'b0, 1);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            if ($urandom_range(0, 24) == 0) begin
                controls = CTRL;
                a = $urandom_range(0, 7);
                b = $urandom_range(0, 7);
                controls[63-8*a -: 8] = controls[63-8*b -: 8];
            end
            pick = $urandom_range(0, 9);
            if (pick < 8)       code = controls[63-8*pick -: 8];
            else if (pick == 8) code = 8'h00;
            else                code = 8'($urandom());
            applyStimulus(code, 1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end

        applyStimulus(8'd0, 1'b0, 10);
        checkOutput("queue_drained", 8'(expq.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
